// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs instruction fields into a 32-bit word with a range-check
// flag, tags it with a sequential byte address and queues it in a 2-entry output FIFO.
module inst_encoder #(
    parameter int ADDR_W             = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [15:0]       err_cnt
);

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_IS = 3'd2;
    localparam logic [2:0] FMT_S  = 3'd3;
    localparam logic [2:0] FMT_B  = 3'd4;
    localparam logic [2:0] FMT_U  = 3'd5;
    localparam logic [2:0] FMT_J  = 3'd6;

    localparam logic [31:0]       NOP_INST  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] BASE_INIT = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    logic [31:0]       enc_inst;
    logic              enc_err;
    logic              push;
    logic              pop;
    logic              full;
    logic [ADDR_W-1:0] word_addr;

    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [31:0]       inst_mem_q [2];
    logic [31:0]       inst_mem_d [2];
    logic [ADDR_W-1:0] addr_mem_q [2];
    logic [ADDR_W-1:0] addr_mem_d [2];
    logic              err_mem_q [2];
    logic              err_mem_d [2];

    // Illegal immediates are still encoded from their truncated bits; only the flag reports them.
    always_comb begin
        enc_inst = NOP_INST;
        enc_err  = 1'b1;
        case (in_fmt)
            FMT_R: begin
                enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_err  = 1'b0;
            end
            FMT_I: begin
                enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err  = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
            end
            FMT_IS: begin
                enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err  = |in_imm[31:5];
            end
            FMT_S: begin
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_err  = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
            end
            FMT_B: begin
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_err  = ~((&in_imm[31:12]) | ~(|in_imm[31:12])) | in_imm[0];
            end
            FMT_U: begin
                enc_inst = {in_imm[31:12], in_rd, in_opcode};
                enc_err  = |in_imm[11:0];
            end
            FMT_J: begin
                enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_err  = ~((&in_imm[31:20]) | ~(|in_imm[31:20])) | in_imm[0];
            end
            default: begin
                enc_inst = NOP_INST;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign full      = (count_q == 2'd2);
    assign in_ready  = ~full & ~rst;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign word_addr = addr_load ? addr_value : addr_cnt_q;

    // A load takes priority over the running counter, both for the pushed word and the next one.
    always_comb begin
        addr_cnt_d = addr_cnt_q;
        if (push) begin
            addr_cnt_d = word_addr + ADDR_STEP;
        end else if (addr_load) begin
            addr_cnt_d = addr_value;
        end
    end

    always_comb begin
        inst_mem_d = inst_mem_q;
        addr_mem_d = addr_mem_q;
        err_mem_d  = err_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_cnt_d  = err_cnt_q;
        if (push) begin
            inst_mem_d[wr_ptr_q] = enc_inst;
            addr_mem_d[wr_ptr_q] = word_addr;
            err_mem_d[wr_ptr_q]  = enc_err;
            wr_ptr_d             = ~wr_ptr_q;
            if (enc_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            addr_cnt_q    <= BASE_INIT;
            err_cnt_q     <= 16'd0;
            inst_mem_q[0] <= 32'd0;
            inst_mem_q[1] <= 32'd0;
            addr_mem_q[0] <= '0;
            addr_mem_q[1] <= '0;
            err_mem_q[0]  <= 1'b0;
            err_mem_q[1]  <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            addr_cnt_q <= addr_cnt_d;
            err_cnt_q  <= err_cnt_d;
            inst_mem_q <= inst_mem_d;
            addr_mem_q <= addr_mem_d;
            err_mem_q  <= err_mem_d;
        end
    end

    assign out_inst = inst_mem_q[rd_ptr_q];
    assign out_addr = addr_mem_q[rd_ptr_q];
    assign out_err  = err_mem_q[rd_ptr_q];
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a table of single-word encodings followed by hand-written
// sequences for backpressure, address wrap/load and mid-stream reset.
module tb_inst_encoder;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_value;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [15:0]       err_cnt;

    int pass_count;
    int check_count;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .addr_load  (addr_load),
        .addr_value (addr_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setFields(input vec_t v);
        in_fmt    = v.fmt;
        in_opcode = v.opcode;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    // Drives one field set for a single cycle; returns #1 after the capturing edge.
    task automatic applyStimulus(input vec_t v, input logic load, input logic [ADDR_W-1:0] lval);
        setFields(v);
        addr_load  = load;
        addr_value = lval;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        addr_load = 1'b0;
    endtask

    function automatic vec_t mkAddi(input logic [31:0] imm);
        vec_t v;
        v.fmt = 3'd1; v.opcode = 7'h13; v.rd = 5'd1; v.rs1 = 5'd0; v.rs2 = 5'd0;
        v.f3 = 3'd0; v.f7 = 7'd0; v.imm = imm;
        v.exp_inst = {imm[11:0], 20'h00093};
        v.exp_err = 1'b0;
        return v;
    endfunction

    initial begin
        logic [ADDR_W-1:0] exp_addr;
        logic [15:0]       exp_cnt;
        int                pushes;
        int                pops;
        logic              fire_push;
        logic              fire_pop;
        vec_t              v;

        pass_count  = 0;
        check_count = 0;
        in_valid = 1'b0; addr_load = 1'b0; addr_value = '0; out_ready = 1'b1;
        in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;

        //            fmt   op     rd    rs1   rs2    f3    f7     imm            exp_inst       err
        vecs[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'h1F, 3'd0, 7'h7F, 32'h0000_0005, 32'h0050_0093, 1'b0};
        vecs[1]  = '{3'd4, 7'h63, 5'd0, 5'd1, 5'd2,  3'd0, 7'd0,  32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0};
        vecs[2]  = '{3'd6, 7'h6F, 5'd1, 5'd0, 5'd0,  3'd0, 7'd0,  32'h0000_0800, 32'h0010_00EF, 1'b0};
        vecs[3]  = '{3'd2, 7'h13, 5'd1, 5'd1, 5'd0,  3'd1, 7'd0,  32'h0000_0003, 32'h0030_9093, 1'b0};
        vecs[4]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0,  3'd0, 7'd0,  32'h0000_0800, 32'h8000_0093, 1'b1};
        vecs[5]  = '{3'd4, 7'h63, 5'd0, 5'd0, 5'd0,  3'd0, 7'd0,  32'h0000_0003, 32'h0000_0163, 1'b1};
        vecs[6]  = '{3'd7, 7'h33, 5'd3, 5'd1, 5'd2,  3'd0, 7'd0,  32'h0000_0000, 32'h0000_0013, 1'b1};
        vecs[7]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2,  3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0};
        vecs[8]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2,  3'd0, 7'h20, 32'h0000_0000, 32'h4020_81B3, 1'b0};
        vecs[9]  = '{3'd3, 7'h23, 5'd0, 5'd1, 5'd2,  3'd2, 7'd0,  32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0};
        vecs[10] = '{3'd5, 7'h37, 5'd5, 5'd0, 5'd0,  3'd0, 7'd0,  32'h1234_5000, 32'h1234_52B7, 1'b0};
        vecs[11] = '{3'd5, 7'h37, 5'd5, 5'd0, 5'd0,  3'd0, 7'd0,  32'h1234_5001, 32'h1234_52B7, 1'b1};
        vecs[12] = '{3'd2, 7'h13, 5'd1, 5'd1, 5'd0,  3'd1, 7'd0,  32'h0000_0020, 32'h0000_9093, 1'b1};
        vecs[13] = '{3'd6, 7'h6F, 5'd1, 5'd0, 5'd0,  3'd0, 7'd0,  32'h0000_0001, 32'h0000_00EF, 1'b1};
        vecs[14] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0,  3'd0, 7'd0,  32'hFFFF_F800, 32'h8000_0093, 1'b0};
        vecs[15] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0,  3'd0, 7'd0,  32'h0000_07FF, 32'h7FF0_0093, 1'b0};

        // Reset state.
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_inst", out_inst, 32'd0);
        checkOutput("rst_out_addr", {22'd0, out_addr}, 32'd0);
        checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
        checkOutput("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven single-word encodings, streaming with out_ready held high.
        exp_addr = '0;
        exp_cnt  = 16'd0;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            applyStimulus(vecs[i], 1'b0, '0);
            if (vecs[i].exp_err) exp_cnt++;
            checkOutput($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("v%0d_inst", i), out_inst, vecs[i].exp_inst);
            checkOutput($sformatf("v%0d_addr", i), {22'd0, out_addr}, {22'd0, exp_addr});
            checkOutput($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
            checkOutput($sformatf("v%0d_err_cnt", i), {16'd0, err_cnt}, {16'd0, exp_cnt});
            exp_addr = exp_addr + 10'd4;
        end
        @(posedge clk); #1;
        checkOutput("table_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: fill to two, verify stall and stable head, then drain in order.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        setFields(mkAddi(32'd1));
        in_valid = 1'b1;
        @(posedge clk); #1;
        setFields(mkAddi(32'd2));
        @(posedge clk); #1;
        checkOutput("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_full_head_inst", out_inst, 32'h0010_0093);
        @(posedge clk); #1;
        checkOutput("bp_stable_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_stable_inst", out_inst, 32'h0010_0093);
        checkOutput("bp_stable_addr", {22'd0, out_addr}, 32'd0);
        checkOutput("bp_still_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        pushes = 2;
        pops   = 0;
        for (int cyc = 0; cyc < 20 && pops < 4; cyc++) begin
            fire_push = in_valid & in_ready;
            fire_pop  = out_valid & out_ready;
            if (fire_pop) begin
                v = mkAddi(32'(pops + 1));
                checkOutput($sformatf("bp_pop%0d_inst", pops), out_inst, v.exp_inst);
                checkOutput($sformatf("bp_pop%0d_addr", pops), {22'd0, out_addr}, 32'(pops * 4));
                pops++;
            end
            @(posedge clk); #1;
            if (fire_push) begin
                pushes++;
                if (pushes == 3) in_valid = 1'b0;
            end
            if (pushes == 2 && in_valid) setFields(mkAddi(32'd3));
        end
        checkOutput("bp_pop_count", 32'(pops), 32'd3);
        checkOutput("bp_push_count", 32'(pushes), 32'd3);

        // Address load with push, then wrap at 2^ADDR_W.
        applyStimulus(mkAddi(32'd7), 1'b1, 10'h3FC);
        checkOutput("wrap_load_addr", {22'd0, out_addr}, 32'h3FC);
        applyStimulus(mkAddi(32'd8), 1'b0, '0);
        checkOutput("wrap_next_addr", {22'd0, out_addr}, 32'h000);
        checkOutput("wrap_next_inst", out_inst, 32'h0080_0093);
        applyStimulus(mkAddi(32'd9), 1'b0, '0);
        checkOutput("wrap_after_addr", {22'd0, out_addr}, 32'h004);
        // Load without a push only retargets the counter.
        addr_load = 1'b1; addr_value = 10'h100;
        @(posedge clk); #1;
        addr_load = 1'b0;
        checkOutput("load_idle_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(mkAddi(32'd10), 1'b0, '0);
        checkOutput("load_idle_addr", {22'd0, out_addr}, 32'h100);
        @(posedge clk); #1;

        // Reset with a full buffer of flagged words.
        out_ready = 1'b0;
        v = vecs[6];
        applyStimulus(v, 1'b0, '0);
        applyStimulus(v, 1'b0, '0);
        checkOutput("mid_rst_pre_cnt", {16'd0, err_cnt}, 32'd2);
        checkOutput("mid_rst_pre_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
        applyStimulus(mkAddi(32'd11), 1'b0, '0);
        checkOutput("mid_rst_first_addr", {22'd0, out_addr}, 32'd0);
        checkOutput("mid_rst_first_inst", out_inst, 32'h00B0_0093);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder: the inverse of the core's immediate-extension/decode path. Accepts instruction fields (format, opcode, registers, functs, 32-bit immediate) over a valid/ready handshake, packs them into a 32-bit RV32I word, tags each word with a sequential byte address, and emits it through a 2-entry output buffer. It feeds the instruction-memory loader and test-program generator. Each word carries a range-check flag for illegal immediates.

## Interface
- ADDR_W, 10, width of byte address counter / out_addr
- BASE_ADDR, 0, address counter value after reset
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  field set present
- in_ready  out  1  encoder can accept; = ~full & ~rst
- in_fmt  in  3  0=R, 1=I, 2=I-shift, 3=S, 4=B, 5=U, 6=J, 7=illegal
- in_opcode  in  7  placed at [6:0]
- in_rd, in_rs1, in_rs2  in  5 each  placed at [11:7], [19:15], [24:20] where format uses them
- in_funct3  in  3  placed at [14:12] (R, I, I-shift, S, B)
- in_funct7  in  7  placed at [31:25] (R, I-shift)
- in_imm  in  32  immediate, full two's-complement value
- addr_load  in  1  load address counter
- addr_value  in  ADDR_W  value for addr_load
- out_valid  out  1  buffer head valid
- out_ready  in  1  consumer accepts head
- out_inst  out  32  encoded word
- out_addr  out  ADDR_W  byte address of word
- out_err  out  1  immediate out of range / misaligned, or illegal fmt
- err_cnt  out  16  saturating count of accepted words with err

## Operation
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- Encoding: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; I-shift {f7,imm[4:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Range check (err=1 if violated; word still encoded from truncated bits): I/S: imm[31:11] all equal; I-shift: imm[31:5]==0; B: imm[31:12] all equal and imm[0]==0; J: imm[31:20] all equal and imm[0]==0; U: imm[11:0]==0; R: imm ignored, never errs.
- fmt=7: out_inst=32'h00000013 (nop), err=1.
- Address counter: on push, word gets current counter, counter += 4 modulo 2^ADDR_W (wraps silently). addr_load has priority: word pushed same cycle gets addr_value, counter becomes addr_value+4. addr_load without push: counter = addr_value.
- Buffer: 2-entry FIFO of {inst, addr, err}, in-order. err_cnt increments on push with err, saturates at 16'hFFFF.

## Timing
- Reset values: out_valid=0, out_inst=0, out_addr=0, out_err=0, err_cnt=0, counter=BASE_ADDR, buffer empty; in_ready=0 while rst high, 1 the cycle after.
- Latency 1: word pushed at edge N is visible at buffer head (out_valid=1) after edge N if buffer was empty.
- Throughput 1 word/cycle with out_ready held high; push and pop in the same cycle allowed at occupancy 1 (occupancy unchanged).
- Full (2 entries): in_ready=0; pop at full frees slot, in_ready=1 next cycle (no same-cycle refill at full).
- out_* stable while out_valid & ~out_ready.
- rst mid-operation: buffer flushed, in-flight words discarded, counter to BASE_ADDR, err_cnt cleared next cycle.

## Test plan
- fmt=1 op=0x13 rd=1 rs1=0 f3=0 imm=5, out_ready=1 -> out_inst=0x00500093, out_addr=0, out_err=0, one cycle after push.
- fmt=4 op=0x63 rs1=1 rs2=2 f3=0 imm=0xFFFFFFF8 then fmt=6 op=0x6F rd=1 imm=0x800 -> 0xFE208CE3 @0, 0x001000EF @4; fmt=2 op=0x13 rd=1 rs1=1 f3=1 f7=0 imm=3 -> 0x00309093.
- fmt=1 op=0x13 rd=1 imm=0x800 -> out_inst=0x80000093, out_err=1, err_cnt=1; fmt=4 imm=3 -> err=1, err_cnt=2; fmt=7 -> 0x00000013, err=1.
- out_ready=0, in_valid held for 3 words -> in_ready low after 2 pushes; release out_ready -> words drained in order, addrs 0,4,8, none lost or duplicated.
- ADDR_W=10, addr_load=1 addr_value=0x3FC with push, then push -> addrs 0x3FC, 0x000 (wrap).
- Fill buffer, assert rst one cycle -> out_valid=0, err_cnt=0, next push gets addr BASE_ADDR.
